// File: rtl/xm_decode_pkg.sv
// Shared decode types for the X-Makina decode stage: operation classes, ALU blocks, opcodes, constants.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package xm_decode_pkg;

    // Instruction class as seen by the control FSM
    typedef enum logic [2:0] {
        OP_BL   = 3'd0,
        OP_BRC  = 3'd1,
        OP_ALU  = 3'd2,
        OP_LD   = 3'd3,
        OP_STR  = 3'd4,
        OP_LDR  = 3'd5,
        OP_ST   = 3'd6,
        OP_MOVI = 3'd7
    } op_e;

    // ALU functional unit selector
    typedef enum logic [1:0] {
        BLK_ARITH = 2'd0,
        BLK_LOGIC = 2'd1,
        BLK_SHIFT = 2'd2,
        BLK_MOVE  = 2'd3
    } alu_blk_e;

    // ALU opcodes, inst[11:8]
    localparam logic [3:0] OPC_ADD  = 4'b0000;
    localparam logic [3:0] OPC_ADDC = 4'b0001;
    localparam logic [3:0] OPC_SUB  = 4'b0010;
    localparam logic [3:0] OPC_SUBC = 4'b0011;
    localparam logic [3:0] OPC_DADD = 4'b0100;
    localparam logic [3:0] OPC_CMP  = 4'b0101;
    localparam logic [3:0] OPC_XOR  = 4'b0110;
    localparam logic [3:0] OPC_AND  = 4'b0111;
    localparam logic [3:0] OPC_BIT  = 4'b1000;
    localparam logic [3:0] OPC_BIC  = 4'b1001;
    localparam logic [3:0] OPC_BIS  = 4'b1010;
    localparam logic [3:0] OPC_MOV  = 4'b1011;
    localparam logic [3:0] OPC_SWAP = 4'b1100;
    localparam logic [3:0] OPC_SHFT = 4'b1101;
    localparam logic [3:0] OPC_RSVD = 4'b1110;
    localparam logic [3:0] OPC_BYTE = 4'b1111;

    // Full decoded bundle, registered as one word at the top level
    typedef struct packed {
        op_e         operation;
        logic        byte_inst;
        logic        src_op_type;
        logic [2:0]  src_op;
        logic [2:0]  dst_op;
        alu_blk_e    alu_block_sel;
        logic [1:0]  alu_block_func;
        logic        alu_no_wb;
        logic [1:0]  imm_mov_wb;
        logic [2:0]  branch_cond;
        logic [15:0] imm_val;
        logic [15:0] addr_offset;
        logic [15:0] branch_offset;
    } dec_bundle_t;

    // Constant generator table indexed by the 3-bit source field
    function automatic logic [15:0] const_val(input logic [2:0] idx);
        logic [15:0] v;
        v = 16'h0000;
        case (idx)
            3'd0: v = 16'h0000;
            3'd1: v = 16'h0001;
            3'd2: v = 16'h0002;
            3'd3: v = 16'h0004;
            3'd4: v = 16'h0008;
            3'd5: v = 16'h0010;
            3'd6: v = 16'h0020;
            3'd7: v = 16'hFFFF;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational split of one 16-bit instruction into the decode bundle; fields unused by a class stay 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inst_data continuously.
module inst_field_decode
    import xm_decode_pkg::*;
(
    input  logic [15:0]  inst_data,
    output dec_bundle_t  dec
);

    logic [3:0] opc;
    logic [7:0] mov_byte;

    // Class detection, then per-class field extraction
    always_comb begin
        dec      = '0;
        opc      = inst_data[11:8];
        mov_byte = inst_data[10:3];

        if (inst_data[15:13] == 3'b000) begin
            dec.operation     = OP_BL;
            dec.branch_offset = {{2{inst_data[12]}}, inst_data[12:0], 1'b0};
        end else if (inst_data[15:13] == 3'b001) begin
            dec.operation     = OP_BRC;
            dec.branch_cond   = inst_data[12:10];
            dec.branch_offset = {{5{inst_data[9]}}, inst_data[9:0], 1'b0};
        end else if (inst_data[15:12] == 4'b0100) begin
            dec.operation   = OP_ALU;
            dec.byte_inst   = inst_data[6];
            dec.src_op_type = inst_data[7];
            dec.src_op      = inst_data[5:3];
            dec.dst_op      = inst_data[2:0];
            case (opc)
                OPC_ADD:  begin dec.alu_block_sel = BLK_ARITH; dec.alu_block_func = 2'd0; end
                OPC_ADDC: begin dec.alu_block_sel = BLK_ARITH; dec.alu_block_func = 2'd2; end
                OPC_SUB:  begin dec.alu_block_sel = BLK_ARITH; dec.alu_block_func = 2'd1; end
                OPC_SUBC: begin dec.alu_block_sel = BLK_ARITH; dec.alu_block_func = 2'd3; end
                OPC_DADD: begin dec.alu_block_sel = BLK_SHIFT; dec.alu_block_func = 2'd2; end
                OPC_CMP:  begin
                    dec.alu_block_sel  = BLK_ARITH;
                    dec.alu_block_func = 2'd1;
                    dec.alu_no_wb      = 1'b1;
                end
                OPC_XOR:  begin dec.alu_block_sel = BLK_LOGIC; dec.alu_block_func = 2'd0; end
                OPC_AND:  begin dec.alu_block_sel = BLK_LOGIC; dec.alu_block_func = 2'd1; end
                OPC_BIT:  begin
                    dec.alu_block_sel  = BLK_LOGIC;
                    dec.alu_block_func = 2'd1;
                    dec.alu_no_wb      = 1'b1;
                end
                OPC_BIC:  begin dec.alu_block_sel = BLK_LOGIC; dec.alu_block_func = 2'd2; end
                OPC_BIS:  begin dec.alu_block_sel = BLK_LOGIC; dec.alu_block_func = 2'd3; end
                OPC_MOV:  begin dec.alu_block_sel = BLK_MOVE;  dec.alu_block_func = 2'd0; end
                OPC_SWAP: begin dec.alu_block_sel = BLK_MOVE;  dec.alu_block_func = 2'd1; end
                OPC_SHFT: begin
                    // Single-operand shifts reuse inst[7] as the sub-opcode, not a constant flag
                    dec.alu_block_sel  = BLK_SHIFT;
                    dec.alu_block_func = inst_data[7] ? 2'd1 : 2'd0;
                    dec.src_op_type    = 1'b0;
                end
                OPC_BYTE: begin
                    dec.alu_block_sel  = BLK_MOVE;
                    dec.alu_block_func = inst_data[7] ? 2'd2 : 2'd3;
                    dec.src_op_type    = 1'b0;
                end
                default: begin
                    // Reserved opcode executes as a NOP: no result is written back
                    dec.alu_block_sel  = BLK_ARITH;
                    dec.alu_block_func = 2'd0;
                    dec.alu_no_wb      = 1'b1;
                end
            endcase
            if (dec.src_op_type) begin
                dec.imm_val = const_val(dec.src_op);
            end
        end else if (inst_data[15:11] == 5'b01010) begin
            dec.operation = OP_LD;
            dec.byte_inst = inst_data[6];
            dec.src_op    = inst_data[5:3];
            dec.dst_op    = inst_data[2:0];
        end else if (inst_data[15:11] == 5'b01011) begin
            // Register-indirect store carries no offset; inst[10:7] are ignored
            dec.operation = OP_ST;
            dec.byte_inst = inst_data[6];
            dec.src_op    = inst_data[5:3];
            dec.dst_op    = inst_data[2:0];
        end else if (inst_data[15:13] == 3'b011) begin
            dec.operation  = OP_MOVI;
            dec.imm_mov_wb = inst_data[12:11];
            dec.dst_op     = inst_data[2:0];
            case (inst_data[12:11])
                2'b00:   dec.imm_val = {8'h00, mov_byte};
                2'b01:   dec.imm_val = {8'h00, mov_byte};
                2'b10:   dec.imm_val = {8'hFF, mov_byte};
                default: dec.imm_val = {mov_byte, 8'h00};
            endcase
        end else begin
            // Relative load/store: inst[15]=1, inst[14] picks store (1) or load (0)
            dec.operation   = inst_data[14] ? OP_STR : OP_LDR;
            dec.byte_inst   = inst_data[6];
            dec.src_op      = inst_data[5:3];
            dec.dst_op      = inst_data[2:0];
            dec.addr_offset = {{9{inst_data[13]}}, inst_data[13:7]};
        end
    end

endmodule

// File: rtl/instruction_decoder_unit.sv
// Decode stage: registers the combinational field decode of inst_data for the control FSM.
// Latency: 1 cycle from inst_data to outputs when en is high.
// Backpressure: none; en low holds the registered bundle unchanged.
module instruction_decoder_unit
    import xm_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] inst_data,
    output logic [2:0]  operation,
    output logic        byte_inst,
    output logic        src_op_type,
    output logic [2:0]  src_op,
    output logic [2:0]  dst_op,
    output logic [1:0]  alu_block_sel,
    output logic [1:0]  alu_block_func,
    output logic        alu_no_wb,
    output logic [1:0]  imm_mov_wb,
    output logic [2:0]  branch_cond,
    output logic [15:0] imm_val,
    output logic [15:0] addr_offset,
    output logic [15:0] branch_offset
);

    dec_bundle_t dec_w;
    dec_bundle_t bundle_d;
    dec_bundle_t bundle_q;

    inst_field_decode u_field_decode (
        .inst_data (inst_data),
        .dec       (dec_w)
    );

    // Load a fresh decode only when enabled, otherwise hold
    always_comb begin
        bundle_d = bundle_q;
        if (en) begin
            bundle_d = dec_w;
        end
    end

    // Output register stage, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bundle_q <= '0;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign operation      = bundle_q.operation;
    assign byte_inst      = bundle_q.byte_inst;
    assign src_op_type    = bundle_q.src_op_type;
    assign src_op         = bundle_q.src_op;
    assign dst_op         = bundle_q.dst_op;
    assign alu_block_sel  = bundle_q.alu_block_sel;
    assign alu_block_func = bundle_q.alu_block_func;
    assign alu_no_wb      = bundle_q.alu_no_wb;
    assign imm_mov_wb     = bundle_q.imm_mov_wb;
    assign branch_cond    = bundle_q.branch_cond;
    assign imm_val        = bundle_q.imm_val;
    assign addr_offset    = bundle_q.addr_offset;
    assign branch_offset  = bundle_q.branch_offset;

endmodule

// File: tb/tb_instruction_decoder_unit.sv
// Directed-vector bench for instruction_decoder_unit with hand-computed expected bundles.
// Latency: checks one cycle after each enabled edge.
// Backpressure: exercises en=0 hold and asynchronous reset override.
module tb_instruction_decoder_unit;
    import xm_decode_pkg::*;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] inst_data;
    logic [2:0]  operation;
    logic        byte_inst;
    logic        src_op_type;
    logic [2:0]  src_op;
    logic [2:0]  dst_op;
    logic [1:0]  alu_block_sel;
    logic [1:0]  alu_block_func;
    logic        alu_no_wb;
    logic [1:0]  imm_mov_wb;
    logic [2:0]  branch_cond;
    logic [15:0] imm_val;
    logic [15:0] addr_offset;
    logic [15:0] branch_offset;

    int checks;
    int errors;

    instruction_decoder_unit dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .inst_data      (inst_data),
        .operation      (operation),
        .byte_inst      (byte_inst),
        .src_op_type    (src_op_type),
        .src_op         (src_op),
        .dst_op         (dst_op),
        .alu_block_sel  (alu_block_sel),
        .alu_block_func (alu_block_func),
        .alu_no_wb      (alu_no_wb),
        .imm_mov_wb     (imm_mov_wb),
        .branch_cond    (branch_cond),
        .imm_val        (imm_val),
        .addr_offset    (addr_offset),
        .branch_offset  (branch_offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, act, exp);
        end
    endtask

    // Compare every output port against a full expected bundle
    task automatic chk_bundle(input string tag, input dec_bundle_t e);
        chk({tag, ".operation"},      {13'd0, operation},      {13'd0, e.operation});
        chk({tag, ".byte_inst"},      {15'd0, byte_inst},      {15'd0, e.byte_inst});
        chk({tag, ".src_op_type"},    {15'd0, src_op_type},    {15'd0, e.src_op_type});
        chk({tag, ".src_op"},         {13'd0, src_op},         {13'd0, e.src_op});
        chk({tag, ".dst_op"},         {13'd0, dst_op},         {13'd0, e.dst_op});
        chk({tag, ".alu_block_sel"},  {14'd0, alu_block_sel},  {14'd0, e.alu_block_sel});
        chk({tag, ".alu_block_func"}, {14'd0, alu_block_func}, {14'd0, e.alu_block_func});
        chk({tag, ".alu_no_wb"},      {15'd0, alu_no_wb},      {15'd0, e.alu_no_wb});
        chk({tag, ".imm_mov_wb"},     {14'd0, imm_mov_wb},     {14'd0, e.imm_mov_wb});
        chk({tag, ".branch_cond"},    {13'd0, branch_cond},    {13'd0, e.branch_cond});
        chk({tag, ".imm_val"},        imm_val,                 e.imm_val);
        chk({tag, ".addr_offset"},    addr_offset,             e.addr_offset);
        chk({tag, ".branch_offset"},  branch_offset,           e.branch_offset);
    endtask

    // Present an instruction with en high, clock it in, sample #1 after the edge
    task automatic decode(input logic [15:0] inst);
        @(negedge clk);
        inst_data = inst;
        en        = 1'b1;
        @(posedge clk);
        #1;
    endtask

    dec_bundle_t e;
    dec_bundle_t held;

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        en        = 1'b0;
        inst_data = 16'h4254;
        #1;
        e = '0;
        chk_bundle("reset", e);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk_bundle("reset_hold_with_en", e);
        @(negedge clk);
        reset = 1'b1;

        // sub.b R2,R4
        decode(16'h4254);
        e = '0; e.operation = OP_ALU; e.alu_block_func = 2'd1; e.byte_inst = 1'b1;
        e.src_op = 3'd2; e.dst_op = 3'd4;
        chk_bundle("sub_b", e);

        // BL with negative offset
        decode(16'h1FFE);
        e = '0; e.operation = OP_BL; e.branch_offset = 16'hFFFC;
        chk_bundle("bl", e);

        // CMP R1,R0
        decode(16'h4508);
        e = '0; e.operation = OP_ALU; e.alu_block_func = 2'd1; e.alu_no_wb = 1'b1;
        e.src_op = 3'd1;
        chk_bundle("cmp", e);

        // STR R3,R5,#62
        decode(16'hDF1D);
        e = '0; e.operation = OP_STR; e.addr_offset = 16'h003E; e.src_op = 3'd3; e.dst_op = 3'd5;
        chk_bundle("str", e);

        // MOVLS #0xAA,R0
        decode(16'h7550);
        e = '0; e.operation = OP_MOVI; e.imm_mov_wb = 2'd2; e.imm_val = 16'hFFAA;
        chk_bundle("movls", e);

        // SRA R1
        decode(16'h4D01);
        e = '0; e.operation = OP_ALU; e.alu_block_sel = BLK_SHIFT; e.dst_op = 3'd1;
        chk_bundle("sra", e);

        // SXT R7: inst[7] set but constant flag forced off
        decode(16'h4F87);
        e = '0; e.operation = OP_ALU; e.alu_block_sel = BLK_MOVE; e.alu_block_func = 2'd2;
        e.dst_op = 3'd7;
        chk_bundle("sxt", e);

        // RRC R3
        decode(16'h4D83);
        e = '0; e.operation = OP_ALU; e.alu_block_sel = BLK_SHIFT; e.alu_block_func = 2'd1;
        e.dst_op = 3'd3;
        chk_bundle("rrc", e);

        // XOR #2,R4
        decode(16'h4694);
        e = '0; e.operation = OP_ALU; e.alu_block_sel = BLK_LOGIC; e.src_op_type = 1'b1;
        e.src_op = 3'd2; e.dst_op = 3'd4; e.imm_val = 16'h0002;
        chk_bundle("xor_const", e);

        // ADD #-1,R2: top entry of constant table
        decode(16'h40BA);
        e = '0; e.operation = OP_ALU; e.src_op_type = 1'b1; e.src_op = 3'd7; e.dst_op = 3'd2;
        e.imm_val = 16'hFFFF;
        chk_bundle("add_const_m1", e);

        // Conditional branch, cond 3, offset +2
        decode(16'h2C01);
        e = '0; e.operation = OP_BRC; e.branch_cond = 3'd3; e.branch_offset = 16'h0002;
        chk_bundle("brc_pos", e);

        // Conditional branch, cond 7, most negative offset
        decode(16'h3E00);
        e = '0; e.operation = OP_BRC; e.branch_cond = 3'd7; e.branch_offset = 16'hFC00;
        chk_bundle("brc_neg", e);

        // LD register indirect
        decode(16'h5123);
        e = '0; e.operation = OP_LD; e.src_op = 3'd4; e.dst_op = 3'd3;
        chk_bundle("ld", e);

        // ST register indirect, byte, reserved bits set
        decode(16'h5963);
        e = '0; e.operation = OP_ST; e.byte_inst = 1'b1; e.src_op = 3'd4; e.dst_op = 3'd3;
        chk_bundle("st", e);

        // LDR with offset -1
        decode(16'hBF8A);
        e = '0; e.operation = OP_LDR; e.addr_offset = 16'hFFFF; e.src_op = 3'd1; e.dst_op = 3'd2;
        chk_bundle("ldr_neg", e);

        // MOVH #0xFF,R7
        decode(16'h7FFF);
        e = '0; e.operation = OP_MOVI; e.imm_mov_wb = 2'd3; e.imm_val = 16'hFF00; e.dst_op = 3'd7;
        chk_bundle("movh", e);

        // MOVL #0x01,R0
        decode(16'h6008);
        e = '0; e.operation = OP_MOVI; e.imm_val = 16'h0001;
        chk_bundle("movl", e);

        // Reserved ALU opcode behaves as NOP without writeback
        decode(16'h4E05);
        chk({"rsvd", ".operation"}, {13'd0, operation}, 16'd2);
        chk({"rsvd", ".alu_block_sel"}, {14'd0, alu_block_sel}, 16'd0);
        chk({"rsvd", ".alu_block_func"}, {14'd0, alu_block_func}, 16'd0);
        chk({"rsvd", ".alu_no_wb"}, {15'd0, alu_no_wb}, 16'd1);

        // Hold: load BIS, then change inst_data with en low for two edges
        decode(16'h4A0B);
        held = '0; held.operation = OP_ALU; held.alu_block_sel = BLK_LOGIC;
        held.alu_block_func = 2'd3; held.src_op = 3'd1; held.dst_op = 3'd3;
        chk_bundle("bis", held);
        @(negedge clk);
        en = 1'b0;
        inst_data = 16'h1FFE;
        @(posedge clk);
        #1;
        chk_bundle("hold1", held);
        @(negedge clk);
        inst_data = 16'h7FFF;
        @(posedge clk);
        #1;
        chk_bundle("hold2", held);

        // Asynchronous reset between edges clears immediately and overrides en
        decode(16'hDF1D);
        #2;
        reset = 1'b0;
        #1;
        e = '0;
        chk_bundle("async_reset", e);
        @(posedge clk);
        #1;
        chk_bundle("reset_overrides_en", e);
        @(negedge clk);
        reset = 1'b1;
        inst_data = 16'h4254;
        @(posedge clk);
        #1;
        e = '0; e.operation = OP_ALU; e.alu_block_func = 2'd1; e.byte_inst = 1'b1;
        e.src_op = 3'd2; e.dst_op = 3'd4;
        chk_bundle("resume", e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_decoder_unit.md
Name: instruction_decoder_unit

Overview:
- Decode stage of the X-Makina multi-cycle CPU: splits one 16-bit instruction word into a registered bundle of control fields for the control unit, ALU, register file and address logic.
- Sits between the instruction register and the control FSM.
- Purely combinational decode followed by a single output register stage.

Parameters:
- none; all widths are fixed by the ISA.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  decode enable; outputs update only when high.
- inst_data  in  16  instruction word.
- operation  out  3  instruction class (encoding below).
- byte_inst  out  1  byte-sized operation (inst[6]).
- src_op_type  out  1  ALU source select: 0 = register, 1 = constant (inst[7]).
- src_op  out  3  source register or constant index (inst[5:3]).
- dst_op  out  3  destination register (inst[2:0]).
- alu_block_sel  out  2  ALU unit: 0 arith, 1 logic, 2 shift/BCD, 3 move/byte.
- alu_block_func  out  2  function within the selected unit.
- alu_no_wb  out  1  suppress writeback of the result (CMP, BIT, reserved).
- imm_mov_wb  out  2  MOV-immediate writeback mode (inst[12:11]).
- branch_cond  out  3  condition code for conditional branches (inst[12:10]).
- imm_val  out  16  immediate operand.
- addr_offset  out  16  sign-extended load/store offset.
- branch_offset  out  16  sign-extended byte branch offset.

Behaviour:
- Reset (reset=0, asynchronous) clears every output to 0.
- On each posedge with en=1, all outputs load the decode of inst_data. Latency is 1 cycle.
- With en=0, outputs hold their previous values.
- Any field that does not apply to the decoded class is driven 0.
- Class decode and operation encoding:
  - inst[15:13]=000 -> 0 BL. branch_offset = sext(inst[12:0])<<1.
  - inst[15:13]=001 -> 1 conditional branch. branch_cond = inst[12:10]; branch_offset = sext(inst[9:0])<<1.
  - inst[15:12]=0100 -> 2 ALU.
  - inst[15:11]=01010 -> 3 LD (register indirect).
  - inst[15:11]=01011 -> 6 ST (register indirect). inst[10:7] are reserved for this class; addr_offset = 0.
  - inst[15:13]=011 -> 7 MOV-immediate.
  - inst[15:14]=11 -> 4 STR (relative).
  - inst[15:14]=10 -> 5 LDR (relative).
- STR/LDR: addr_offset = sext(inst[13:7]); src_op, dst_op and byte_inst are also driven.
- ALU opcode inst[11:8] -> {block, func}:
  - 0000 ADD {0,0}; 0001 ADDC {0,2}; 0010 SUB {0,1}; 0011 SUBC {0,3}.
  - 0100 DADD {2,2}; 0101 CMP {0,1} with no_wb.
  - 0110 XOR {1,0}; 0111 AND {1,1}; 1000 BIT {1,1} with no_wb; 1001 BIC {1,2}; 1010 BIS {1,3}.
  - 1011 MOV {3,0}; 1100 SWAP {3,1}.
  - 1101: inst[7]=0 SRA {2,0}, inst[7]=1 RRC {2,1}.
  - 1111: inst[7]=0 SWPB {3,3}, inst[7]=1 SXT {3,2}.
  - 1110 reserved -> NOP: block/func 0, alu_no_wb=1.
  - For the 1101 and 1111 groups, src_op_type is forced to 0.
- ALU constant: when src_op_type=1, imm_val = constant table[src_op] = {0, 1, 2, 4, 8, 16, 32, 0xFFFF}.
- MOV-immediate, with b = inst[10:3]:
  - imm_mov_wb 00 MOVL: imm_val = {00, b}.
  - imm_mov_wb 01 MOVLZ: imm_val = {00, b}.
  - imm_mov_wb 10 MOVLS: imm_val = {FF, b}.
  - imm_mov_wb 11 MOVH: imm_val = {b, 00}.
- Reset asserted mid-stream overrides en; decode resumes on the first posedge after release.

Decomposition:
- Package xm_decode_pkg holds:
  - operation enum (BL, BRC, ALU, LD, STR, LDR, ST, MOVI);
  - ALU block enum;
  - ALU opcode constants;
  - constant table.
- One combinational sub-module, inst_field_decode, produces the next-state bundle; the top level registers it.

Test Plan:
- 0x4254 (sub.b R2,R4) -> operation 2, block 0, func 1, byte 1, src 2, dst 4, no_wb 0.
- 0x1FFE (BL) -> operation 0, branch_offset 0xFFFC; then 0x4508 (CMP R1,R0) -> block 0, func 1, no_wb 1, src 1, dst 0.
- 0xDF1D (STR R3,R5,#62) -> operation 4, addr_offset 0x003E, src 3, dst 5.
- 0x7550 (MOVLS) -> operation 7, imm_mov_wb 2, imm_val 0xFFAA, dst 0.
- 0x4D01 (SRA R1) -> block 2, func 0, dst 1; then 0x4F87 (SXT R7) -> block 3, func 2; then 0x4694 (XOR #2,R4) -> block 1, func 0, src_op_type 1, imm_val 0x0002.
- en=0 while inst_data changes -> outputs hold; assert reset between edges -> all outputs 0 immediately.
